// File: rtl/ins_fetch_buffer.sv
// Instruction fetch buffer: fetches words from a req/ack instruction memory into
// a PC-tagged FIFO that feeds the decoder over valid/ready, with redirect flush.
module ins_fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        ins_valid,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  input  logic        ins_ready
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_r;
  logic [31:0]   ins_mem_r [DEPTH];
  logic [31:0]   pc_mem_r  [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW:0]   count_r;
  logic [AW:0]   count_next_s;
  logic [31:0]   fetch_pc_r;
  logic [31:0]   next_addr_s;
  logic          xfer_s;
  logic          push_s;
  logic          pop_s;
  logic          space_s;

  assign ins_valid   = (count_r != {(AW + 1){1'b0}});
  assign ins         = ins_mem_r[rd_ptr_r];
  assign ins_pc      = pc_mem_r[rd_ptr_r];
  assign next_addr_s = imem_addr + 32'd4;

  // Handshake qualifiers and the post-edge occupancy that gates new requests.
  always_comb begin
    xfer_s  = imem_req && imem_ack;
    pop_s   = ins_valid && ins_ready;
    push_s  = xfer_s && (state_r == REQ) && !redirect;
    if (redirect) begin
      count_next_s = {(AW + 1){1'b0}};
    end else begin
      count_next_s = count_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
    end
    space_s = (count_next_s < DEPTH_C);
  end

  // FIFO pointers and occupancy; a redirect flushes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
    end else if (redirect) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      count_r <= count_next_s;
    end
  end

  // Entry storage, cleared at reset so an empty buffer presents zeros.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ins_mem_r[i] <= 32'h0000_0000;
        pc_mem_r[i]  <= 32'h0000_0000;
      end
    end else if (push_s) begin
      ins_mem_r[wr_ptr_r] <= imem_rdata;
      pc_mem_r[wr_ptr_r]  <= imem_addr;
    end
  end

  // Fetch control FSM; request and address are registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      fetch_pc_r <= RESET_PC;
    end else begin
      if (redirect) begin
        fetch_pc_r <= redirect_pc;
      end
      case (state_r)
        IDLE: begin
          if (!redirect && space_s) begin
            state_r   <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc_r;
          end
        end
        REQ: begin
          if (redirect) begin
            // Without an ack the request must stay up at the old address.
            if (xfer_s) begin
              state_r  <= IDLE;
              imem_req <= 1'b0;
            end else begin
              state_r <= DRAIN;
            end
          end else if (xfer_s) begin
            fetch_pc_r <= next_addr_s;
            if (space_s) begin
              imem_addr <= next_addr_s;
            end else begin
              state_r  <= IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (xfer_s) begin
            state_r  <= IDLE;
            imem_req <= 1'b0;
          end
        end
        default: begin
          state_r  <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ins_fetch_buffer.sv
// Scoreboard bench for ins_fetch_buffer: directed scenarios push expected
// {pc, word} pairs; a negedge monitor checks every consumed instruction.
module tb_ins_fetch_buffer;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ins_valid;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        ins_ready;

  int tests_run    = 0;
  int tests_failed = 0;
  int mem_lat      = 0;
  int wait_cnt     = 0;
  int xfer_cnt     = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  ins_fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .ins_valid   (ins_valid),
    .ins         (ins),
    .ins_pc      (ins_pc),
    .ins_ready   (ins_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a == 32'h0000_0008) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_5A5A);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ins(input logic [31:0] pc);
    sb_q.push_back({pc, data_of(pc)});
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    redirect  = 1'b0;
    ins_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  // Memory model: acks after mem_lat idle cycles of a raised request.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'h0000_0000;
    forever begin
      @(negedge clk);
      if (imem_ack) wait_cnt = 0;
      if (imem_req && wait_cnt >= mem_lat) begin
        imem_ack   = 1'b1;
        imem_rdata = data_of(imem_addr);
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'h0000_0000;
        if (imem_req) wait_cnt++;
        else wait_cnt = 0;
      end
    end
  end

  always @(posedge clk) begin
    if (imem_req && imem_ack) xfer_cnt <= xfer_cnt + 1;
  end

  // Monitor: every consumption must match the next scoreboard entry.
  always @(negedge clk) begin
    if (ins_valid && ins_ready) begin
      if (sb_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL sb_unexpected: got pc %h, expected no instruction", ins_pc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_pc", ins_pc, mon_e.pc);
        chk("sb_ins", ins, mon_e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0000_0000;
    ins_ready   = 1'b0;
    #1 rst = 1'b0;
    #2;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_0000);
    chk("rst_valid", 32'(ins_valid), 32'd0);
    chk("rst_ins", ins, 32'h0000_0000);
    chk("rst_pc", ins_pc, 32'h0000_0000);

    // Streaming with zero-wait memory, then reset mid-request.
    mem_lat = 0;
    do_reset();
    ins_ready = 1'b1;
    for (int i = 0; i < 6; i++) expect_ins(32'(4 * i));
    tick();
    chk("t1_req", 32'(imem_req), 32'd1);
    chk("t1_addr0", imem_addr, 32'h0000_0000);
    chk("t1_valid0", 32'(ins_valid), 32'd0);
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("t1_addr", imem_addr, 32'(4 * i));
      chk("t1_valid", 32'(ins_valid), 32'd1);
      chk("t1_pc", ins_pc, 32'(4 * (i - 1)));
    end
    rst = 1'b0;
    #1;
    chk("rst_mid_req", 32'(imem_req), 32'd0);
    chk("rst_mid_valid", 32'(ins_valid), 32'd0);
    chk("t1_sb_empty", 32'(sb_q.size()), 32'd0);

    // Fill with consumer stalled; one pop opens exactly one request.
    mem_lat = 0;
    do_reset();
    base = xfer_cnt;
    expect_ins(32'h0); expect_ins(32'h4); expect_ins(32'h8);
    expect_ins(32'hC); expect_ins(32'h10);
    repeat (5) tick();
    chk("t2_req_off", 32'(imem_req), 32'd0);
    repeat (3) tick();
    chk("t2_req_hold", 32'(imem_req), 32'd0);
    chk("t2_xfers4", 32'(xfer_cnt - base), 32'd4);
    chk("t2_valid", 32'(ins_valid), 32'd1);
    ins_ready = 1'b1;
    tick();
    ins_ready = 1'b0;
    chk("t2_req_again", 32'(imem_req), 32'd1);
    chk("t2_addr10", imem_addr, 32'h0000_0010);
    tick();
    chk("t2_req_full", 32'(imem_req), 32'd0);
    chk("t2_xfers5", 32'(xfer_cnt - base), 32'd5);
    ins_ready = 1'b1;
    repeat (4) tick();
    ins_ready = 1'b0;
    chk("t2_sb_empty", 32'(sb_q.size()), 32'd0);

    // Three wait states per request: address held, request stays high.
    mem_lat = 3;
    do_reset();
    ins_ready = 1'b1;
    expect_ins(32'h0); expect_ins(32'h4); expect_ins(32'h8);
    for (int e = 1; e <= 16; e++) begin
      tick();
      chk("t3_req", 32'(imem_req), 32'd1);
      chk("t3_addr", imem_addr, 32'(4 * ((e - 1) / 4)));
    end
    chk("t3_sb_empty", 32'(sb_q.size()), 32'd0);

    // Redirect while the request at 0x8 waits; its late word is dropped.
    mem_lat = 3;
    do_reset();
    ins_ready = 1'b1;
    expect_ins(32'h0); expect_ins(32'h4); expect_ins(32'h100);
    repeat (10) tick();
    chk("t4_addr8", imem_addr, 32'h0000_0008);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick();
    redirect = 1'b0;
    chk("t4_drain_req", 32'(imem_req), 32'd1);
    chk("t4_drain_addr", imem_addr, 32'h0000_0008);
    chk("t4_drain_valid", 32'(ins_valid), 32'd0);
    tick();
    chk("t4_wait_req", 32'(imem_req), 32'd1);
    chk("t4_wait_addr", imem_addr, 32'h0000_0008);
    tick();
    chk("t4_idle_req", 32'(imem_req), 32'd0);
    chk("t4_idle_valid", 32'(ins_valid), 32'd0);
    tick();
    chk("t4_new_req", 32'(imem_req), 32'd1);
    chk("t4_new_addr", imem_addr, 32'h0000_0100);
    repeat (4) tick();
    chk("t4_valid", 32'(ins_valid), 32'd1);
    chk("t4_pc", ins_pc, 32'h0000_0100);
    tick();
    chk("t4_sb_empty", 32'(sb_q.size()), 32'd0);

    // Redirect coinciding with an ack and a pop.
    mem_lat = 0;
    do_reset();
    ins_ready = 1'b1;
    expect_ins(32'h0); expect_ins(32'h4); expect_ins(32'h8); expect_ins(32'h40);
    repeat (4) tick();
    chk("t5_pc8", ins_pc, 32'h0000_0008);
    chk("t5_addrC", imem_addr, 32'h0000_000C);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0040;
    tick();
    redirect = 1'b0;
    chk("t5_flush_valid", 32'(ins_valid), 32'd0);
    chk("t5_flush_req", 32'(imem_req), 32'd0);
    tick();
    chk("t5_req", 32'(imem_req), 32'd1);
    chk("t5_addr40", imem_addr, 32'h0000_0040);
    chk("t5_valid0", 32'(ins_valid), 32'd0);
    tick();
    chk("t5_valid", 32'(ins_valid), 32'd1);
    chk("t5_pc40", ins_pc, 32'h0000_0040);
    tick();
    chk("t5_sb_empty", 32'(sb_q.size()), 32'd0);

    // Flush a full FIFO, then fetch across the top of the address space.
    mem_lat = 0;
    do_reset();
    expect_ins(32'hFFFF_FFF8); expect_ins(32'hFFFF_FFFC); expect_ins(32'h0);
    repeat (6) tick();
    chk("t6_full_valid", 32'(ins_valid), 32'd1);
    chk("t6_full_req", 32'(imem_req), 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    chk("t6_flush_valid", 32'(ins_valid), 32'd0);
    chk("t6_flush_req", 32'(imem_req), 32'd0);
    ins_ready = 1'b1;
    tick();
    chk("t6_addr_f8", imem_addr, 32'hFFFF_FFF8);
    tick();
    chk("t6_addr_fc", imem_addr, 32'hFFFF_FFFC);
    chk("t6_pc_f8", ins_pc, 32'hFFFF_FFF8);
    tick();
    chk("t6_addr_wrap", imem_addr, 32'h0000_0000);
    chk("t6_pc_fc", ins_pc, 32'hFFFF_FFFC);
    tick();
    chk("t6_addr4", imem_addr, 32'h0000_0004);
    chk("t6_pc0", ins_pc, 32'h0000_0000);
    tick();
    ins_ready = 1'b0;
    chk("t6_sb_empty", 32'(sb_q.size()), 32'd0);

    rst = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ins_fetch_buffer.md
Name: ins_fetch_buffer

Overview:
- Instruction fetch stage directly upstream of the single-cycle core's decoder.
- Fetches 32-bit words from a multi-cycle instruction memory over a req/ack handshake.
- Holds prefetched instructions, each tagged with its PC, in a small FIFO and presents them to the core with valid/ready.
- A redirect from the core's branch/PC-write logic flushes the FIFO and restarts fetch at a new PC.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, ≥2)
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- redirect  input  1  flush and restart fetch at redirect_pc
- redirect_pc  input  32  new fetch address (word aligned)
- imem_req  output  1  fetch request, registered
- imem_addr  output  32  fetch address, registered, stable while imem_req high
- imem_ack  input  1  memory returns imem_rdata this cycle
- imem_rdata  input  32  instruction word
- ins_valid  output  1  FIFO head holds a valid instruction
- ins  output  32  head instruction
- ins_pc  output  32  address of head instruction
- ins_ready  input  1  core consumes head this cycle

Behaviour:
- Reset (rst low, async): state IDLE; count=0; rd/wr pointers=0; fetch_pc=RESET_PC.
  - Outputs at reset: imem_req=0, imem_addr=RESET_PC, ins_valid=0.
  - Storage cleared to 0, so ins=0 and ins_pc=0.
- Reset asserted mid-transaction abandons it. The memory side must tolerate a dropped request.
- FSM states:
  - IDLE: imem_req=0.
  - REQ: imem_req=1; data is kept.
  - DRAIN: imem_req=1; data is discarded.
  - At most one request outstanding.
- Transfer occurs on any cycle with imem_req && imem_ack. Ack in the first cycle req is high is legal.
- Space rule: a new request is issued only if count_next < DEPTH, where count_next is the post-edge count.
- IDLE → REQ, when no redirect and space is available:
  - imem_addr ← fetch_pc.
- REQ, on ack without redirect:
  - Push {imem_rdata, imem_addr}.
  - fetch_pc ← imem_addr+4 (mod 2^32; 0xFFFF_FFFC wraps to 0).
  - If space remains: stay in REQ with imem_addr ← imem_addr+4 (back-to-back; 1 word/cycle with zero-wait memory).
  - Otherwise go to IDLE.
- REQ, no ack: hold imem_addr; req stays high.
- Redirect (highest priority over push), on the clock edge:
  - FIFO flushed: count=0, pointers=0.
  - fetch_pc ← redirect_pc.
  - IDLE + redirect: stay IDLE; request issued the following cycle.
  - REQ + redirect without ack: go to DRAIN. Req stays high at the old address until ack.
  - REQ + redirect with ack, or DRAIN + redirect with ack: data discarded; go to IDLE.
  - DRAIN + redirect without ack: stay DRAIN; fetch_pc updated again (last redirect wins).
- DRAIN, on ack: discard data; go to IDLE. The next request goes to fetch_pc.
- Output side:
  - ins_valid = (count != 0), combinational from state registers.
  - Pop on ins_valid && ins_ready.
  - A pop in the same cycle as redirect is a valid consumption; the flush still clears the rest of the FIFO.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Overflow is impossible by the space rule.
- Pop when empty is ignored.
- Pointers wrap modulo DEPTH.
- Redirect-to-first-valid latency is 3 cycles with zero-wait memory:
  - edge 1: IDLE → REQ
  - edge 2: push
  - ins_valid high after edge 2

Test Plan:
- Reset then release; imem_ack tied 1; ins_ready=1 → imem_addr 0,4,8,… on consecutive cycles; ins_pc follows one cycle behind; ins_valid continuous after the first word.
- ins_ready=0, ack always 1, DEPTH=4 → exactly 4 transfers (PC 0x0–0xC), then imem_req=0. Raising ins_ready for one cycle yields one new request at 0x10.
- imem_ack delayed 3 cycles per request → imem_addr stable and req high throughout each wait; FIFO contents match addresses in order.
- Redirect to 0x100 while REQ at 0x8 is waiting; ack arrives 2 cycles later with 0xDEADBEEF → word discarded; FIFO empty; next request at 0x100; first ins_pc=0x100.
- Redirect to 0x40 in the same cycle as an ack and a pop → popped entry consumed; acked word dropped; next ins_pc=0x40; count=0 in between.
- redirect_pc=0xFFFF_FFF8, zero-wait memory → fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0. Asserting rst low mid-REQ forces imem_req=0 and ins_valid=0 immediately.
